// File: rtl/mod_n_counter_sched.sv
// Round-robin scheduler that lends one external mod-N counter to two clients,
// stepping it K times per job and counting wrap-arounds seen on its output.
module mod_n_counter_sched #(
  parameter int WIDTH  = 2,
  parameter int N      = 3,
  parameter int STEP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_dir,
  input  logic [STEP_W-1:0] i_steps0,
  input  logic [STEP_W-1:0] i_steps1,
  input  logic [WIDTH-1:0]  i_cnt_q,
  output logic              o_cnt_en,
  output logic              o_cnt_up_down,
  output logic [1:0]        o_ack,
  output logic [1:0]        o_done,
  output logic              o_busy,
  output logic              o_owner,
  output logic [STEP_W-1:0] o_wrap_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(N - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              dir_q, dir_d;
  logic              ptr_q, ptr_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [STEP_W-1:0] wrap_q, wrap_d;
  logic              sel;
  logic              wrap_hit;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (&v) ? v : v + STEP_W'(1);
  endfunction

  // The counter's current value is the one it will leave on this enable cycle.
  assign wrap_hit = dir_q ? (i_cnt_q == CNT_MAX) : (i_cnt_q == '0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    wrap_d  = wrap_q;
    sel     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          sel     = (i_req == 2'b11) ? ptr_q : i_req[1];
          owner_d = sel;
          dir_d   = i_dir[sel];
          rem_d   = sel ? i_steps1 : i_steps0;
          wrap_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        state_d = (rem_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        rem_d = rem_q - STEP_W'(1);
        if (wrap_hit) wrap_d = sat_inc(wrap_q);
        if (rem_q == STEP_W'(1)) state_d = S_DONE;
      end
      default: begin
        ptr_d   = ~owner_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      ptr_q   <= 1'b0;
      rem_q   <= '0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end

  // Outputs are pure state decode, so an async reset clears them at once.
  assign o_cnt_en      = (state_q == S_RUN);
  assign o_cnt_up_down = (state_q == S_RUN) && dir_q;
  assign o_ack         = (state_q == S_GRANT) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_done        = (state_q == S_DONE)  ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_busy        = (state_q != S_IDLE);
  assign o_owner       = owner_q;
  assign o_wrap_cnt    = wrap_q;

endmodule

// File: tb/tb_mod_n_counter_sched.sv
// Directed bench for mod_n_counter_sched: a behavioural mod-N counter closes
// the loop, and two narrow-STEP_W instances cover wrap counting and saturation.
module tb_mod_n_counter_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] req, dir;
  logic [7:0] steps0, steps1;
  logic [1:0] cnt;
  logic       cnt_en, cnt_ud, busy, owner;
  logic [1:0] ack, done;
  logic [7:0] wrap;
  logic       ld;
  logic [1:0] ld_val;

  logic [1:0] req_s, dir_s;
  logic [3:0] ss0, ss1;
  logic [1:0] cnt_a;
  logic [0:0] cnt_b;
  logic       en_a, ud_a, busy_a, owner_a, en_b, ud_b, busy_b, owner_b;
  logic [1:0] ack_a, done_a, ack_b, done_b;
  logic [3:0] wrap_a, wrap_b;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] cap[$];

  mod_n_counter_sched #(.WIDTH(2), .N(3), .STEP_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_dir(dir),
    .i_steps0(steps0), .i_steps1(steps1), .i_cnt_q(cnt),
    .o_cnt_en(cnt_en), .o_cnt_up_down(cnt_ud), .o_ack(ack), .o_done(done),
    .o_busy(busy), .o_owner(owner), .o_wrap_cnt(wrap));

  mod_n_counter_sched #(.WIDTH(2), .N(3), .STEP_W(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_s), .i_dir(dir_s),
    .i_steps0(ss0), .i_steps1(ss1), .i_cnt_q(cnt_a),
    .o_cnt_en(en_a), .o_cnt_up_down(ud_a), .o_ack(ack_a), .o_done(done_a),
    .o_busy(busy_a), .o_owner(owner_a), .o_wrap_cnt(wrap_a));

  mod_n_counter_sched #(.WIDTH(1), .N(2), .STEP_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_s), .i_dir(dir_s),
    .i_steps0(ss0), .i_steps1(ss1), .i_cnt_q(cnt_b),
    .o_cnt_en(en_b), .o_cnt_up_down(ud_b), .o_ack(ack_b), .o_done(done_b),
    .o_busy(busy_b), .o_owner(owner_b), .o_wrap_cnt(wrap_b));

  // Behavioural mod-3 / mod-2 counters fed by the scheduler's enable outputs
  always_ff @(posedge clk) begin
    if (ld) begin
      cnt   <= ld_val;
      cnt_a <= ld_val;
      cnt_b <= ld_val[0];
    end else begin
      if (cnt_en) begin
        if (cnt_ud) cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
        else        cnt <= (cnt == 2'd0) ? 2'd2 : cnt - 2'd1;
      end
      if (en_a) begin
        if (ud_a) cnt_a <= (cnt_a == 2'd2) ? 2'd0 : cnt_a + 2'd1;
        else      cnt_a <= (cnt_a == 2'd0) ? 2'd2 : cnt_a - 2'd1;
      end
      if (en_b) cnt_b <= ud_b ? ~cnt_b : ~cnt_b;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input logic [1:0] exp_ack, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 40);
    check_eq({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check_eq({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic run_body(input string tag, input logic [1:0] exp_done, input logic exp_dir,
                          input int exp_k, input int exp_wrap);
    int k, bad;
    k = 0;
    bad = 0;
    cap.delete();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cnt_en) begin
        k++;
        cap.push_back(cnt);
        if (cnt_ud !== exp_dir) bad++;
      end else break;
    end
    check_eq({tag, "_en_cycles"}, k, exp_k);
    check_eq({tag, "_dir_errs"}, bad, 0);
    check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
    check_eq({tag, "_busy"}, 32'(busy), 1);
    check_eq({tag, "_wrap"}, 32'(wrap), exp_wrap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] e1[5];
    logic [1:0] e2[4];
    int k, seen;
    e1 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    e2 = '{2'd2, 2'd1, 2'd0, 2'd2};
    rst_n = 1'b0; req = 2'b00; dir = 2'b00; steps0 = 8'd0; steps1 = 8'd0;
    ld = 1'b1; ld_val = 2'd0; req_s = 2'b00; dir_s = 2'b00; ss0 = 4'd0; ss1 = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_en", 32'(cnt_en), 0);
    check_eq("rst_ud", 32'(cnt_ud), 0);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_owner", 32'(owner), 0);
    check_eq("rst_wrap", 32'(wrap), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ld = 1'b0;

    // single up job, client 0, 5 steps from 0
    req = 2'b01; dir = 2'b01; steps0 = 8'd5;
    wait_ack("t1", 2'b01, 2);
    req = 2'b00;
    run_body("t1", 2'b01, 1'b1, 5, 1);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t1_q%0d", i), 32'(cap[i]), 32'(e1[i]));
    check_eq("t1_final_cnt", 32'(cnt), 2);
    check_eq("t1_owner", 32'(owner), 0);

    // down job, client 1, 4 steps from 2; owner's inputs change after ack
    @(posedge clk); #1;
    req = 2'b10; dir = 2'b00; steps1 = 8'd4;
    wait_ack("t2", 2'b10, 2);
    req = 2'b00; steps1 = 8'd9; dir = 2'b10;
    run_body("t2", 2'b10, 1'b0, 4, 1);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t2_q%0d", i), 32'(cap[i]), 32'(e2[i]));
    check_eq("t2_final_cnt", 32'(cnt), 1);
    check_eq("t2_owner", 32'(owner), 1);

    // zero-step job
    @(posedge clk); #1;
    req = 2'b01; dir = 2'b01; steps0 = 8'd0;
    wait_ack("t3", 2'b01, 2);
    req = 2'b00;
    run_body("t3", 2'b01, 1'b1, 0, 0);
    @(negedge clk);
    check_eq("t3_idle", 32'(busy), 0);
    check_eq("t3_cnt", 32'(cnt), 1);

    // contention from reset: client 0 first, then client 1
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 2'b11; dir = 2'b11; steps0 = 8'd2; steps1 = 8'd3;
    wait_ack("t4a", 2'b01, 2);
    req = 2'b10;
    run_body("t4a", 2'b01, 1'b1, 2, 1);
    wait_ack("t4b", 2'b10, 2);
    req = 2'b00;
    run_body("t4b", 2'b10, 1'b1, 3, 1);
    check_eq("t4_cnt", 32'(cnt), 0);

    // swapped order: client 1 requests alone, client 0 joins while busy
    @(posedge clk); #1;
    req = 2'b10; steps0 = 8'd1; steps1 = 8'd1;
    wait_ack("t4c", 2'b10, 2);
    req = 2'b01;
    run_body("t4c", 2'b10, 1'b1, 1, 0);
    wait_ack("t4d", 2'b01, 2);
    req = 2'b00;
    run_body("t4d", 2'b01, 1'b1, 1, 0);
    check_eq("t4_cnt2", 32'(cnt), 2);

    // client 1 pulses a request while busy and drops it before any ack
    @(posedge clk); #1;
    req = 2'b01; dir = 2'b00; steps0 = 8'd3;
    wait_ack("t5", 2'b01, 2);
    req = 2'b10;
    fork
      begin
        repeat (2) @(negedge clk);
        req = 2'b00;
      end
      run_body("t5", 2'b01, 1'b0, 3, 1);
    join
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != 2'b00) seen++;
    end
    check_eq("t5_no_ack", seen, 0);
    check_eq("t5_idle", 32'(busy), 0);

    // reset on the 3rd enable cycle of a 6-step job owned by client 1
    @(posedge clk); #1;
    req = 2'b10; dir = 2'b10; steps1 = 8'd6;
    wait_ack("t6", 2'b10, 2);
    req = 2'b00;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cnt_en) k++;
      if (k == 3) break;
    end
    check_eq("t6_en3", k, 3);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_en", 32'(cnt_en), 0);
    check_eq("t6_rst_busy", 32'(busy), 0);
    check_eq("t6_rst_ack", 32'(ack), 0);
    check_eq("t6_rst_done", 32'(done), 0);
    check_eq("t6_rst_ud", 32'(cnt_ud), 0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done != 2'b00) seen++;
    end
    check_eq("t6_no_done", seen, 0);
    check_eq("t6_cnt", 32'(cnt), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 2'b11; dir = 2'b11; steps0 = 8'd1; steps1 = 8'd1;
    wait_ack("t6r", 2'b01, 2);
    req = 2'b00;
    run_body("t6r", 2'b01, 1'b1, 1, 0);

    // maximum step count
    @(posedge clk); #1;
    ld = 1'b1; ld_val = 2'd0;
    @(posedge clk); #1;
    ld = 1'b0;
    req = 2'b01; dir = 2'b01; steps0 = 8'd255;
    wait_ack("t7", 2'b01, 2);
    req = 2'b00;
    run_body("t7", 2'b01, 1'b1, 255, 85);

    // STEP_W=4 instances: 15 up steps from 0
    @(posedge clk); #1;
    req_s = 2'b01; dir_s = 2'b01; ss0 = 4'd15;
    repeat (2) @(negedge clk);
    check_eq("s1_ack_a", 32'(ack_a), 1);
    check_eq("s1_ack_b", 32'(ack_b), 1);
    req_s = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a != 2'b00) break;
    end
    check_eq("s1_done_a", 32'(done_a), 1);
    check_eq("s1_wrap_a", 32'(wrap_a), 5);
    check_eq("s1_done_b", 32'(done_b), 1);
    check_eq("s1_wrap_b", 32'(wrap_b), 7);

    // second job: preload the N=2 wrap count near the top so it must saturate
    @(posedge clk); #1;
    req_s = 2'b01;
    repeat (2) @(negedge clk);
    check_eq("s2_ack_b", 32'(ack_b), 1);
    req_s = 2'b00;
    repeat (4) @(negedge clk);
    force dut_b.wrap_q = 4'd14;
    @(negedge clk);
    release dut_b.wrap_q;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_b != 2'b00) break;
    end
    check_eq("s2_done_b", 32'(done_b), 1);
    check_eq("s2_wrap_b_sat", 32'(wrap_b), 15);
    check_eq("s2_wrap_a", 32'(wrap_a), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
